// File: rtl/mix_columns_seq.sv
// Iterative AES MixColumns: one shared column datapath walks the four columns
// of a 128-bit state, with an optional pass-through for the final round.
module mix_columns_seq #(
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_bypass,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy,
  output logic [1:0]   col_idx
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    xtime = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

  // Row 0 sits in the MSB byte; each output byte is 2*a_i ^ 3*a_(i+1) ^ a_(i+2) ^ a_(i+3).
  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    mix_col = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
               xtime(a1) ^ xtime(a2) ^ a2 ^ a3 ^ a0,
               xtime(a2) ^ xtime(a3) ^ a3 ^ a0 ^ a1,
               xtime(a3) ^ xtime(a0) ^ a0 ^ a1 ^ a2};
  endfunction

  state_t         r_state;
  logic [127:0]   r_work;
  logic [127:0]   r_result;
  logic [1:0]     r_col;
  logic [31:0]    w_col_in;
  logic [31:0]    w_col_out;

  always_comb begin
    w_col_in = 32'h0000_0000;
    case (r_col)
      2'd0:    w_col_in = r_work[127:96];
      2'd1:    w_col_in = r_work[95:64];
      2'd2:    w_col_in = r_work[63:32];
      2'd3:    w_col_in = r_work[31:0];
      default: w_col_in = 32'h0000_0000;
    endcase
  end

  assign w_col_out = mix_col(w_col_in);

  // flush outranks every transition, including an input handshake in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_work   <= 128'h0;
      r_result <= 128'h0;
      r_col    <= 2'd0;
    end else if (flush) begin
      r_state <= S_IDLE;
      r_col   <= 2'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_work <= in_state;
            r_col  <= 2'd0;
            if (in_bypass && BYPASS_EN) begin
              r_result <= in_state;
              r_state  <= S_DONE;
            end else begin
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          case (r_col)
            2'd0:    r_result[127:96] <= w_col_out;
            2'd1:    r_result[95:64]  <= w_col_out;
            2'd2:    r_result[63:32]  <= w_col_out;
            2'd3:    r_result[31:0]   <= w_col_out;
            default: r_result         <= r_result;
          endcase
          r_col <= r_col + 2'd1;
          if (r_col == 2'd3) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_col   <= 2'd0;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign out_state = r_result;
  assign col_idx   = r_col;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Directed scoreboard bench for mix_columns_seq; a second instance covers
// the BYPASS_EN = 0 build.
module tb_mix_columns_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         in_bypass;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;
  logic [1:0]   col_idx;

  logic         nb_in_valid;
  logic         nb_in_ready;
  logic         nb_out_valid;
  logic [127:0] nb_out_state;
  logic         nb_busy;
  logic [1:0]   nb_col_idx;

  int n_asserts = 0;
  int n_fails   = 0;
  logic [127:0] sb[$];
  logic [127:0] held;

  localparam logic [127:0] FIPS_IN  = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
  localparam logic [127:0] FIPS_OUT = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
  localparam logic [127:0] COL_IN   = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] COL_OUT  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] D4_IN    = {4{32'hd4d4d4d5}};
  localparam logic [127:0] D4_OUT   = {4{32'hd5d5d7d6}};
  localparam logic [127:0] R2_IN    = {4{32'h2d26314c}};
  localparam logic [127:0] R2_OUT   = {4{32'h4d7ebdf8}};

  mix_columns_seq #(.BYPASS_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state), .in_bypass(in_bypass),
    .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
    .busy(busy), .col_idx(col_idx)
  );

  mix_columns_seq #(.BYPASS_EN(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(nb_in_valid), .in_ready(nb_in_ready), .in_state(in_state), .in_bypass(in_bypass),
    .out_valid(nb_out_valid), .out_ready(out_ready), .out_state(nb_out_state),
    .busy(nb_busy), .col_idx(nb_col_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_asserts++;
    assert (got === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Present one block for a single accepting edge; returns at the negedge after it.
  task automatic accept(input logic [127:0] st, input logic byp, input logic [127:0] exp,
                        input bit keep_valid);
    @(negedge clk);
    chk("accept_in_ready", in_ready, 1);
    in_state  = st;
    in_bypass = byp;
    in_valid  = 1'b1;
    sb.push_back(exp);
    @(negedge clk);
    if (!keep_valid) in_valid = 1'b0;
  endtask

  // lat = clock edges after the accepting edge before out_valid is seen.
  task automatic wait_out(input string tag, input int lat, input bit track_col);
    int n;
    logic [127:0] exp;
    n = 0;
    while (!out_valid && n < 20) begin
      if (track_col) begin
        chk({tag, "_col_idx"}, col_idx, n);
        chk({tag, "_busy_run"}, busy, 1);
      end
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, n, lat);
    chk({tag, "_out_valid"}, out_valid, 1);
    exp = (sb.size() > 0) ? sb.pop_front() : 128'hx;
    chk({tag, "_out_state"}, out_state, exp);
  endtask

  task automatic finish_out(input string tag);
    @(negedge clk);
    chk({tag, "_valid_1cyc"}, out_valid, 0);
    chk({tag, "_in_ready_back"}, in_ready, 1);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; nb_in_valid = 1'b0;
    in_state = 128'h0; in_bypass = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_state", out_state, 128'h0);
    chk("rst_busy", busy, 0);
    chk("rst_col_idx", col_idx, 0);
    @(negedge clk);
    rst = 1'b0;

    // FIPS-197 round 1 column mix
    accept(FIPS_IN, 1'b0, FIPS_OUT, 1'b0);
    wait_out("fips", 4, 1'b1);
    finish_out("fips");

    accept(COL_IN, 1'b0, COL_OUT, 1'b0);
    wait_out("colvec", 4, 1'b0);
    finish_out("colvec");

    accept(COL_IN, 1'b1, COL_IN, 1'b0);
    wait_out("bypass", 0, 1'b0);
    finish_out("bypass");

    // BYPASS_EN = 0 build ignores in_bypass
    begin
      int n;
      @(negedge clk);
      in_state = COL_IN; in_bypass = 1'b1; nb_in_valid = 1'b1;
      @(negedge clk);
      nb_in_valid = 1'b0;
      n = 0;
      while (!nb_out_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("nobyp_latency", n, 4);
      chk("nobyp_out_state", nb_out_state, COL_OUT);
      in_bypass = 1'b0;
    end

    // Backpressure with in_valid held high
    out_ready = 1'b0;
    accept(COL_IN, 1'b0, COL_OUT, 1'b1);
    wait_out("bp", 4, 1'b0);
    held = out_state;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_state", out_state, held);
      chk("bp_in_ready_low", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    finish_out("bp");
    chk("bp_no_second_accept", busy, 0);

    // Flush at col_idx = 2
    accept(FIPS_IN, 1'b0, FIPS_OUT, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("flush_at_col2", col_idx, 2);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    void'(sb.pop_back());
    chk("flush_busy", busy, 0);
    chk("flush_in_ready", in_ready, 1);
    chk("flush_col_idx", col_idx, 0);
    for (int i = 0; i < 6; i++) begin
      chk("flush_no_out_valid", out_valid, 0);
      @(negedge clk);
    end
    in_valid = 1'b1; flush = 1'b1; in_state = FIPS_IN;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_idle_no_accept", busy, 0);
    accept(D4_IN, 1'b0, D4_OUT, 1'b0);
    wait_out("post_flush", 4, 1'b0);
    finish_out("post_flush");

    // Async reset between edges mid-RUN
    accept(FIPS_IN, 1'b0, FIPS_OUT, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_busy", busy, 0);
    chk("arst_col_idx", col_idx, 0);
    chk("arst_out_state", out_state, 128'h0);
    void'(sb.pop_back());
    @(negedge clk);
    rst = 1'b0;
    accept(R2_IN, 1'b0, R2_OUT, 1'b0);
    wait_out("post_rst", 4, 1'b0);
    finish_out("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
